// File: rtl/obi_data_arbiter.sv
// obi_data_arbiter
//   Shares one OBI-style RAM data port between two masters:
//     M0 = core data interface, M1 = debug-module system-bus master.
//   Requests use a req/gnt handshake. Responses come back in order on
//   rvalid. A small ID FIFO remembers which master issued each accepted
//   transaction, so that every response goes back to the right master.
//
// Ports
//   clk_i, rst_ni                         clock, asynchronous active-low reset
//   m0_req_i/addr_i/we_i/be_i/wdata_i     M0 request; held until m0_gnt_o
//   m0_gnt_o, m0_rvalid_o, m0_rdata_o     M0 grant and response
//   m1_*                                  same set for M1 (debug SBA master)
//   s_req_o/addr_o/we_o/be_o/wdata_o      request to memory, muxed from the winner
//   s_gnt_i, s_rvalid_i, s_rdata_i        memory grant and in-order response
//   busy_o                                at least one transaction outstanding
//   err_o                                 sticky: response with nothing outstanding

module obi_data_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          RR_EN           = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    m0_req_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,

  input  logic                    m1_req_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,

  output logic                    s_req_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic                    s_gnt_i,
  input  logic                    s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,

  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    SelM0 = 1'b0,
    SelM1 = 1'b1
  } master_e;

  // Outstanding-transaction bookkeeping. The ID FIFO is a shift register
  // whose head is bit 0; bit value 1 means the transaction belongs to M1.
  logic [CntWidth-1:0]        count_q, count_d;
  logic [MAX_OUTSTANDING-1:0] idFifo_q, idFifo_d;
  logic [CntWidth-1:0]        writeIdx;

  logic    lock_q, lock_d;
  master_e lockSel_q, lockSel_d;
  master_e last_q, last_d;
  logic    err_q, err_d;

  master_e sel;
  logic    notFull;
  logic    handshake;
  logic    pop;

  // Full is judged on the registered count only, so a response that frees
  // a slot cannot let a new request through in the same cycle.
  assign notFull   = (count_q < CntWidth'(MAX_OUTSTANDING));
  assign s_req_o   = (m0_req_i | m1_req_i) & notFull;
  assign handshake = s_req_o & s_gnt_i;
  assign pop       = s_rvalid_i & (count_q != '0);

  // Winner selection. A request that was presented but not yet granted
  // keeps its master selected so the memory sees stable request fields.
  // Without a pending lock, round-robin favours the master not granted last.
  always_comb begin
    sel = SelM0;
    if (lock_q) begin
      sel = lockSel_q;
    end else if (m0_req_i && m1_req_i) begin
      sel = (RR_EN && (last_q == SelM0)) ? SelM1 : SelM0;
    end else if (m1_req_i) begin
      sel = SelM1;
    end
  end

  assign m0_gnt_o = handshake & (sel == SelM0);
  assign m1_gnt_o = handshake & (sel == SelM1);

  // Request fields are forced to zero while nothing is presented.
  assign s_addr_o  = s_req_o ? ((sel == SelM1) ? m1_addr_i  : m0_addr_i)  : '0;
  assign s_we_o    = s_req_o & ((sel == SelM1) ? m1_we_i : m0_we_i);
  assign s_be_o    = s_req_o ? ((sel == SelM1) ? m1_be_i    : m0_be_i)    : '0;
  assign s_wdata_o = s_req_o ? ((sel == SelM1) ? m1_wdata_i : m0_wdata_i) : '0;

  assign m0_rvalid_o = pop & ~idFifo_q[0];
  assign m1_rvalid_o = pop &  idFifo_q[0];
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  assign busy_o = (count_q != '0);
  assign err_o  = err_q;

  // Next-state logic. On a simultaneous push and pop the FIFO shifts first,
  // so the new ID lands one slot lower and the order is preserved.
  always_comb begin
    idFifo_d  = idFifo_q;
    count_d   = count_q;
    lock_d    = lock_q;
    lockSel_d = lockSel_q;
    last_d    = last_q;
    err_d     = err_q;
    writeIdx  = count_q - CntWidth'(pop);

    if (pop) begin
      idFifo_d = idFifo_q >> 1;
    end
    if (handshake) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (CntWidth'(i) == writeIdx) begin
          idFifo_d[i] = (sel == SelM1);
        end
      end
    end
    count_d = count_q + CntWidth'(handshake) - CntWidth'(pop);

    if (handshake) begin
      lock_d = 1'b0;
      last_d = sel;
    end else if (s_req_o) begin
      lock_d    = 1'b1;
      lockSel_d = sel;
    end

    if (s_rvalid_i && (count_q == '0)) begin
      err_d = 1'b1;
    end
  end

  // Reset leaves last_q at M1 so that M0 wins the first contested cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q   <= '0;
      idFifo_q  <= '0;
      lock_q    <= 1'b0;
      lockSel_q <= SelM0;
      last_q    <= SelM1;
      err_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      idFifo_q  <= idFifo_d;
      lock_q    <= lock_d;
      lockSel_q <= lockSel_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_obi_data_arbiter.sv
// tb_obi_data_arbiter
//   Two arbiter instances: index 0 uses round-robin, index 1 fixed priority.
//   Each instance has its own stimulus. A transaction-level model of each
//   instance (queue of issuing master IDs, lock and last-grant tracking)
//   predicts every output on every falling edge. Directed sequences add
//   hand-computed expectations on top of the model.

module tb_obi_data_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXO = 2;

  logic clk_i;
  logic rst_ni;

  logic          m0Req[2], m1Req[2], m0We[2], m1We[2];
  logic [AW-1:0] m0Addr[2], m1Addr[2];
  logic [BW-1:0] m0Be[2], m1Be[2];
  logic [DW-1:0] m0Wdata[2], m1Wdata[2];
  logic          sGnt[2], sRvalid[2];
  logic [DW-1:0] sRdata[2];

  logic          m0Gnt[2], m1Gnt[2], m0Rvalid[2], m1Rvalid[2];
  logic [DW-1:0] m0Rdata[2], m1Rdata[2];
  logic          sReq[2], sWe[2], busy[2], errO[2];
  logic [AW-1:0] sAddr[2];
  logic [BW-1:0] sBe[2];
  logic [DW-1:0] sWdata[2];

  // Model state per instance
  int  idQ[2][$];
  bit  mLock[2];
  int  mLockSel[2];
  int  mLast[2];
  bit  mErr[2];
  bit  eSReq[2], eHs[2], ePop[2];
  int  eSel[2];
  bit  gntPrev[2][2];

  int totalChecks = 0;
  int badChecks   = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  obi_data_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .RR_EN(1'b1)
  ) dutRr (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0Req[0]), .m0_addr_i(m0Addr[0]), .m0_we_i(m0We[0]), .m0_be_i(m0Be[0]),
    .m0_wdata_i(m0Wdata[0]), .m0_gnt_o(m0Gnt[0]), .m0_rvalid_o(m0Rvalid[0]), .m0_rdata_o(m0Rdata[0]),
    .m1_req_i(m1Req[0]), .m1_addr_i(m1Addr[0]), .m1_we_i(m1We[0]), .m1_be_i(m1Be[0]),
    .m1_wdata_i(m1Wdata[0]), .m1_gnt_o(m1Gnt[0]), .m1_rvalid_o(m1Rvalid[0]), .m1_rdata_o(m1Rdata[0]),
    .s_req_o(sReq[0]), .s_addr_o(sAddr[0]), .s_we_o(sWe[0]), .s_be_o(sBe[0]), .s_wdata_o(sWdata[0]),
    .s_gnt_i(sGnt[0]), .s_rvalid_i(sRvalid[0]), .s_rdata_i(sRdata[0]),
    .busy_o(busy[0]), .err_o(errO[0])
  );

  obi_data_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .RR_EN(1'b0)
  ) dutFixed (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0Req[1]), .m0_addr_i(m0Addr[1]), .m0_we_i(m0We[1]), .m0_be_i(m0Be[1]),
    .m0_wdata_i(m0Wdata[1]), .m0_gnt_o(m0Gnt[1]), .m0_rvalid_o(m0Rvalid[1]), .m0_rdata_o(m0Rdata[1]),
    .m1_req_i(m1Req[1]), .m1_addr_i(m1Addr[1]), .m1_we_i(m1We[1]), .m1_be_i(m1Be[1]),
    .m1_wdata_i(m1Wdata[1]), .m1_gnt_o(m1Gnt[1]), .m1_rvalid_o(m1Rvalid[1]), .m1_rdata_o(m1Rdata[1]),
    .s_req_o(sReq[1]), .s_addr_o(sAddr[1]), .s_we_o(sWe[1]), .s_be_o(sBe[1]), .s_wdata_o(sWdata[1]),
    .s_gnt_i(sGnt[1]), .s_rvalid_i(sRvalid[1]), .s_rdata_i(sRdata[1]),
    .busy_o(busy[1]), .err_o(errO[1])
  );

  task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                             input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s inst%0d at %0t: got=%h want=%h", name, k, $time, act, exp);
    end
  endtask

  task automatic modelReset(input int k);
    idQ[k].delete();
    mLock[k]      = 1'b0;
    mLockSel[k]   = 0;
    mLast[k]      = 1;
    mErr[k]       = 1'b0;
    gntPrev[k][0] = 1'b0;
    gntPrev[k][1] = 1'b0;
  endtask

  // Predict this cycle's outputs from the transaction-level state and compare.
  task automatic modelEval(input int k);
    int head;
    logic [AW-1:0] expAddr;
    logic [BW-1:0] expBe;
    logic [DW-1:0] expWdata;
    bit expWe;
    eSReq[k] = (m0Req[k] || m1Req[k]) && (idQ[k].size() < MAXO);
    if (mLock[k])                    eSel[k] = mLockSel[k];
    else if (m0Req[k] && m1Req[k])   eSel[k] = (k == 0) ? (1 - mLast[k]) : 0;
    else if (m1Req[k])               eSel[k] = 1;
    else                             eSel[k] = 0;
    eHs[k]  = eSReq[k] && sGnt[k];
    ePop[k] = sRvalid[k] && (idQ[k].size() > 0);
    head    = (idQ[k].size() > 0) ? idQ[k][0] : 0;
    expAddr  = '0;
    expBe    = '0;
    expWdata = '0;
    expWe    = 1'b0;
    if (eSReq[k]) begin
      expAddr  = (eSel[k] == 1) ? m1Addr[k]  : m0Addr[k];
      expBe    = (eSel[k] == 1) ? m1Be[k]    : m0Be[k];
      expWdata = (eSel[k] == 1) ? m1Wdata[k] : m0Wdata[k];
      expWe    = (eSel[k] == 1) ? m1We[k]    : m0We[k];
    end
    checkOutput("s_req",     k, 32'(sReq[k]),     32'(eSReq[k]));
    checkOutput("m0_gnt",    k, 32'(m0Gnt[k]),    32'(eHs[k] && eSel[k] == 0));
    checkOutput("m1_gnt",    k, 32'(m1Gnt[k]),    32'(eHs[k] && eSel[k] == 1));
    checkOutput("m0_rvalid", k, 32'(m0Rvalid[k]), 32'(ePop[k] && head == 0));
    checkOutput("m1_rvalid", k, 32'(m1Rvalid[k]), 32'(ePop[k] && head == 1));
    checkOutput("m0_rdata",  k, m0Rdata[k], sRdata[k]);
    checkOutput("m1_rdata",  k, m1Rdata[k], sRdata[k]);
    checkOutput("s_addr",    k, sAddr[k],  expAddr);
    checkOutput("s_we",      k, 32'(sWe[k]), 32'(expWe));
    checkOutput("s_be",      k, 32'(sBe[k]), 32'(expBe));
    checkOutput("s_wdata",   k, sWdata[k], expWdata);
    checkOutput("busy",      k, 32'(busy[k]), 32'(idQ[k].size() != 0));
    checkOutput("err",       k, 32'(errO[k]), 32'(mErr[k]));
  endtask

  task automatic modelStep(input int k);
    bit errNow;
    errNow = sRvalid[k] && (idQ[k].size() == 0);
    gntPrev[k][0] = eHs[k] && eSel[k] == 0;
    gntPrev[k][1] = eHs[k] && eSel[k] == 1;
    if (ePop[k]) void'(idQ[k].pop_front());
    if (eHs[k]) begin
      idQ[k].push_back(eSel[k]);
      mLast[k] = eSel[k];
      mLock[k] = 1'b0;
    end else if (eSReq[k]) begin
      mLock[k]    = 1'b1;
      mLockSel[k] = eSel[k];
    end
    if (errNow) mErr[k] = 1'b1;
  endtask

  task automatic compareCycle();
    for (int k = 0; k < 2; k++) begin
      if (!rst_ni) modelReset(k);
      modelEval(k);
    end
  endtask

  task automatic advanceModel();
    if (rst_ni) begin
      for (int k = 0; k < 2; k++) modelStep(k);
    end
  endtask

  always @(negedge clk_i) compareCycle();
  always @(posedge clk_i) advanceModel();

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input int k, input bit r0, input logic [31:0] a0,
                               input bit r1, input logic [31:0] a1,
                               input bit gnt, input bit rv, input logic [31:0] rd);
    m0Req[k] = r0;  m0Addr[k] = a0; m0We[k] = 1'b0; m0Be[k] = 4'h3; m0Wdata[k] = ~a0;
    m1Req[k] = r1;  m1Addr[k] = a1; m1We[k] = 1'b1; m1Be[k] = 4'hC; m1Wdata[k] = a1 ^ 32'h5555_5555;
    sGnt[k] = gnt;  sRvalid[k] = rv; sRdata[k] = rd;
  endtask

  task automatic idleAll();
    for (int k = 0; k < 2; k++) applyStimulus(k, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    cycle();
    idleAll();
    rst_ni = 1'b0;
    cycle();
    cycle();
    rst_ni = 1'b1;
  endtask

  task automatic randomPhase(input int n);
    bit pend[2][2];
    for (int k = 0; k < 2; k++) begin
      pend[k][0] = 1'b0;
      pend[k][1] = 1'b0;
    end
    idleAll();
    repeat (n) begin
      cycle();
      for (int k = 0; k < 2; k++) begin
        for (int m = 0; m < 2; m++) begin
          if (pend[k][m] && gntPrev[k][m]) pend[k][m] = 1'b0;
          if (!pend[k][m] && ($urandom_range(0, 99) < 40)) begin
            pend[k][m] = 1'b1;
            if (m == 0) begin
              m0Addr[k] = $urandom; m0We[k] = 1'($urandom_range(0, 1));
              m0Be[k] = 4'($urandom_range(0, 15)); m0Wdata[k] = $urandom;
            end else begin
              m1Addr[k] = $urandom; m1We[k] = 1'($urandom_range(0, 1));
              m1Be[k] = 4'($urandom_range(0, 15)); m1Wdata[k] = $urandom;
            end
          end
        end
        m0Req[k] = pend[k][0];
        m1Req[k] = pend[k][1];
        sGnt[k]  = ($urandom_range(0, 99) < 65);
        if (idQ[k].size() > 0) sRvalid[k] = 1'($urandom_range(0, 1));
        else                   sRvalid[k] = ($urandom_range(0, 99) < 3);
        sRdata[k] = $urandom;
      end
    end
    cycle();
    idleAll();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) modelReset(k);
    idleAll();
    rst_ni = 1'b0;
    cycle();
    @(negedge clk_i);
    checkOutput("rst_busy", 0, 32'(busy[0]), 0);
    checkOutput("rst_err",  0, 32'(errO[0]), 0);
    checkOutput("rst_sreq", 1, 32'(sReq[1]), 0);
    cycle();
    rst_ni = 1'b1;

    // Single M0 read, response one cycle later
    cycle();
    applyStimulus(0, 1, 32'h100, 0, 0, 1, 0, 0);
    @(negedge clk_i);
    checkOutput("t1_gnt",  0, 32'(m0Gnt[0]), 1);
    checkOutput("t1_addr", 0, sAddr[0], 32'h100);
    checkOutput("t1_busy0", 0, 32'(busy[0]), 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    @(negedge clk_i);
    checkOutput("t1_rvalid", 0, 32'(m0Rvalid[0]), 1);
    checkOutput("t1_rdata",  0, m0Rdata[0], 32'hDEAD_BEEF);
    checkOutput("t1_m1rv",   0, 32'(m1Rvalid[0]), 0);
    checkOutput("t1_busy1",  0, 32'(busy[0]), 1);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    checkOutput("t1_busy2", 0, 32'(busy[0]), 0);

    // Lock: M0 waits three cycles, M1 joins and must not steal the slot
    for (int c = 0; c < 8; c++) begin
      cycle();
      case (c)
        0:       applyStimulus(0, 1, 32'h200, 0, 32'h300, 0, 0, 0);
        1, 2:    applyStimulus(0, 1, 32'h200, 1, 32'h300, 0, 0, 0);
        3:       applyStimulus(0, 1, 32'h200, 1, 32'h300, 1, 0, 0);
        4:       applyStimulus(0, 0, 0, 1, 32'h300, 1, 0, 0);
        5, 6:    applyStimulus(0, 0, 0, 0, 0, 0, 1, $urandom);
        default: applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      @(negedge clk_i);
      if (c <= 3) checkOutput("t3_addr", 0, sAddr[0], 32'h200);
      if (c == 4) checkOutput("t3_addr4", 0, sAddr[0], 32'h300);
      if (c <= 4) begin
        checkOutput("t3_m0gnt", 0, 32'(m0Gnt[0]), 32'(c == 3));
        checkOutput("t3_m1gnt", 0, 32'(m1Gnt[0]), 32'(c == 4));
      end
      if (c == 5) checkOutput("t3_m0rv", 0, 32'(m0Rvalid[0]), 1);
      if (c == 6) checkOutput("t3_m1rv", 0, 32'(m1Rvalid[0]), 1);
      if (c == 7) checkOutput("t3_busy", 0, 32'(busy[0]), 0);
    end

    // Full: two outstanding block further grants, even in the pop cycle
    for (int c = 0; c < 9; c++) begin
      cycle();
      case (c)
        0, 1, 2, 4: applyStimulus(0, 1, 32'h40 + c, 0, 0, 1, 0, 0);
        3, 5, 6:    applyStimulus(0, 1, 32'h40 + c, 0, 0, 1, 1, $urandom);
        7:          applyStimulus(0, 0, 0, 0, 0, 0, 1, $urandom);
        default:    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      @(negedge clk_i);
      if (c == 0 || c == 1 || c == 4 || c == 6) checkOutput("t4_gnt", 0, 32'(m0Gnt[0]), 1);
      if (c == 2 || c == 3 || c == 5) begin
        checkOutput("t4_sreq_full", 0, 32'(sReq[0]), 0);
        checkOutput("t4_nogrant",   0, 32'(m0Gnt[0]), 0);
      end
      if (c == 7) checkOutput("t4_lastrv", 0, 32'(m0Rvalid[0]), 1);
      if (c == 8) begin
        checkOutput("t4_busy", 0, 32'(busy[0]), 0);
        checkOutput("t4_err",  0, 32'(errO[0]), 0);
      end
    end

    // Response with nothing outstanding
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h1234);
    @(negedge clk_i);
    checkOutput("t5_m0rv", 0, 32'(m0Rvalid[0]), 0);
    checkOutput("t5_m1rv", 0, 32'(m1Rvalid[0]), 0);
    for (int c = 0; c < 2; c++) begin
      cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      checkOutput("t5_err", 0, 32'(errO[0]), 1);
    end

    // Both masters request every cycle on both instances
    doReset();
    for (int c = 0; c < 5; c++) begin
      cycle();
      for (int k = 0; k < 2; k++)
        applyStimulus(k, c < 4, 32'h10 + c, c < 4, 32'h20 + c, 1, c >= 1, $urandom);
      @(negedge clk_i);
      if (c < 4) begin
        checkOutput("t2_rr_m0gnt",  0, 32'(m0Gnt[0]), 32'(c % 2 == 0));
        checkOutput("t2_rr_m1gnt",  0, 32'(m1Gnt[0]), 32'(c % 2 == 1));
        checkOutput("t2_fix_m0gnt", 1, 32'(m0Gnt[1]), 1);
        checkOutput("t2_fix_m1gnt", 1, 32'(m1Gnt[1]), 0);
      end
      if (c >= 1) begin
        checkOutput("t2_rr_m0rv",  0, 32'(m0Rvalid[0]), 32'((c - 1) % 2 == 0));
        checkOutput("t2_rr_m1rv",  0, 32'(m1Rvalid[0]), 32'((c - 1) % 2 == 1));
        checkOutput("t2_fix_m0rv", 1, 32'(m0Rvalid[1]), 1);
      end
    end
    cycle();
    idleAll();

    // Reset with a transaction outstanding and a locked M1 request
    cycle();
    applyStimulus(0, 1, 32'h400, 0, 0, 1, 0, 0);
    cycle();
    applyStimulus(0, 0, 0, 1, 32'h500, 0, 0, 0);
    @(negedge clk_i);
    checkOutput("t6_addr", 0, sAddr[0], 32'h500);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    checkOutput("t6_busy", 0, 32'(busy[0]), 0);
    cycle();
    rst_ni = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hBAD);
    @(negedge clk_i);
    checkOutput("t6_m0rv", 0, 32'(m0Rvalid[0]), 0);
    checkOutput("t6_err0", 0, 32'(errO[0]), 0);
    cycle();
    applyStimulus(0, 1, 32'h600, 1, 32'h700, 1, 0, 0);
    @(negedge clk_i);
    checkOutput("t6_err1",  0, 32'(errO[0]), 1);
    checkOutput("t6_m0gnt", 0, 32'(m0Gnt[0]), 1);
    checkOutput("t6_m1gnt", 0, 32'(m1Gnt[0]), 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, $urandom);
    @(negedge clk_i);
    checkOutput("t6_drain", 0, 32'(m0Rvalid[0]), 1);

    doReset();
    randomPhase(3000);
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
